// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with sync, blanking
// and frame-start decodes, all derived from registered counter state.
module video_timing_gen #(
    parameter int ACTIVE_H    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int ACTIVE_V    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int FRAME_WRAP  = 60,
    localparam int H_TOTAL    = ACTIVE_H + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL    = ACTIVE_V + V_FRONT + V_SYNC + V_BACK,
    localparam int HW         = $clog2(H_TOTAL),
    localparam int VW         = $clog2(V_TOTAL),
    localparam int FW         = (FRAME_WRAP > 1) ? $clog2(FRAME_WRAP) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] o_hcount,
    output logic [VW-1:0] o_vcount,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active_draw,
    output logic          o_new_frame,
    output logic [FW-1:0] o_frame_count
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(ACTIVE_H);
    localparam logic [HW-1:0] HS_START = HW'(ACTIVE_H + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(ACTIVE_H + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(ACTIVE_V);
    localparam logic [VW-1:0] VS_START = VW'(ACTIVE_V + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(ACTIVE_V + V_FRONT + V_SYNC);
    localparam logic [FW-1:0] F_LAST   = FW'(FRAME_WRAP - 1);

    logic          started;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [FW-1:0] frame_count;
    logic          in_hsync;
    logic          in_vsync;
    logic          new_frame;

    assign in_hsync  = (hcount >= HS_START) && (hcount < HS_END);
    assign in_vsync  = (vcount >= VS_START) && (vcount < VS_END);
    assign new_frame = started && (hcount == H_ACT) && (vcount == V_ACT);

    // The first edge after reset release only arms the generator, so (0,0)
    // is presented for a full cycle before counting begins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            started     <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            frame_count <= '0;
        end else if (!started) begin
            started <= 1'b1;
        end else begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
            if (new_frame) begin
                frame_count <= (frame_count == F_LAST) ? '0 : frame_count + 1'b1;
            end
        end
    end

    // Decodes depend only on flops, so reset forces them without a clock edge.
    assign o_hcount      = hcount;
    assign o_vcount      = vcount;
    assign o_frame_count = frame_count;
    assign o_active_draw = started && (hcount < H_ACT) && (vcount < V_ACT);
    assign o_new_frame   = new_frame;
    assign o_hsync       = (started && in_hsync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_vsync       = (started && in_vsync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: expectations come from an arithmetic
// raster model (elapsed cycles -> position) and are checked by a separate monitor.
module tb_video_timing_gen;

    localparam int AH = 8, HF = 2, HS = 3, HB = 2;
    localparam int AV = 6, VF = 1, VS = 2, VB = 2;
    localparam int FWRAP = 5;
    localparam bit SA = 1'b0;
    localparam int HT  = AH + HF + HS + HB;
    localparam int VT  = AV + VF + VS + VB;
    localparam int HWD = $clog2(HT);
    localparam int VWD = $clog2(VT);
    localparam int FWD = $clog2(FWRAP);
    localparam int FP  = HT * VT;
    localparam int OFF = AV * HT + AH;
    localparam int TGT = (AV + VF + 1) * HT + (AH + HF + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [HWD-1:0] hcount;
    logic [VWD-1:0] vcount;
    logic           hsync, vsync, active_draw, new_frame;
    logic [FWD-1:0] frame_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit ad;
        bit nf;
        int fc;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    bit   m_started = 1'b0;
    int   m_t = 0;

    video_timing_gen #(
        .ACTIVE_H(AH), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .ACTIVE_V(AV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(SA), .FRAME_WRAP(FWRAP)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .o_hcount(hcount),
        .o_vcount(vcount),
        .o_hsync(hsync),
        .o_vsync(vsync),
        .o_active_draw(active_draw),
        .o_new_frame(new_frame),
        .o_frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Position follows from cycles elapsed since the arming edge; frame count
    // from how many new-frame instants lie strictly before now.
    function automatic exp_t model(bit st, int t);
        exp_t e;
        int   n;
        e.h = 0; e.v = 0; e.ad = 1'b0; e.nf = 1'b0; e.fc = 0;
        e.hs = !SA; e.vs = !SA;
        if (st) begin
            e.h  = t % HT;
            e.v  = (t / HT) % VT;
            e.ad = (e.h < AH) && (e.v < AV);
            e.hs = (e.h >= AH + HF && e.h < AH + HF + HS) ? SA : !SA;
            e.vs = (e.v >= AV + VF && e.v < AV + VF + VS) ? SA : !SA;
            e.nf = (e.h == AH) && (e.v == AV);
            n    = (t > OFF) ? ((t - OFF - 1) / FP + 1) : 0;
            e.fc = n % FWRAP;
        end
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (!m_started) begin
                m_started = 1'b1;
                m_t = 0;
            end else begin
                m_t++;
            end
        end
        q.push_back(model(m_started, m_t));
    endtask

    // Asserted between negedge and the next posedge, then checked before that edge.
    task automatic assert_reset();
        @(negedge clk);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        m_started = 1'b0;
        #1;
        q.push_back(model(1'b0, 0));
        ->chk_ev;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        q.push_back(model(1'b0, 0));
        ->chk_ev;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("hcount", 32'(hcount), e.h);
                check("vcount", 32'(vcount), e.v);
                check("hsync", 32'(hsync), int'(e.hs));
                check("vsync", 32'(vsync), int'(e.vs));
                check("active_draw", 32'(active_draw), int'(e.ad));
                check("new_frame", 32'(new_frame), int'(e.nf));
                check("frame_count", 32'(frame_count), e.fc);
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        repeat (3) step();
        release_reset();
        repeat (12 * FP + 20) step();

        assert_reset();
        repeat (2) step();
        release_reset();
        for (int i = 0; i < FP + 2 && !(m_started && m_t == TGT); i++) step();
        assert_reset();
        step();
        release_reset();
        repeat (3) step();

        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(1, 400)) step();
            assert_reset();
            repeat ($urandom_range(0, 2)) step();
            release_reset();
        end
        repeat (FP + 10) step();

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        if (checks < 12) begin
            errors++;
            $display("FAIL check_count: got %0d expected at least 12", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter ACTIVE_H, default 640: visible pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, pixels.
REQ-004 Parameter H_BACK, default 48: horizontal back porch, pixels.
REQ-005 Parameter ACTIVE_V, default 480: visible lines per frame.
REQ-006 Parameter V_FRONT, default 10: vertical front porch, lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, lines.
REQ-008 Parameter V_BACK, default 33: vertical back porch, lines.
REQ-009 Parameter SYNC_ACTIVE, default 0: logic level of o_hsync/o_vsync while asserted.
REQ-010 Parameter FRAME_WRAP, default 60: o_frame_count modulus.
REQ-011 Derived H_TOTAL = sum of the four H parameters (800) and V_TOTAL = sum of the four V parameters (525), with HW = $clog2(H_TOTAL) and VW = $clog2(V_TOTAL).
REQ-012 i_clk  input  1  pixel clock; all state changes on the rising edge.
REQ-013 i_rst_n  input  1  asynchronous, active-low reset.
REQ-014 o_hcount  output  HW  current pixel column, 0..H_TOTAL-1.
REQ-015 o_vcount  output  VW  current line, 0..V_TOTAL-1.
REQ-016 o_hsync  output  1  horizontal sync at SYNC_ACTIVE level while asserted.
REQ-017 o_vsync  output  1  vertical sync at SYNC_ACTIVE level while asserted.
REQ-018 o_active_draw  output  1  high when (o_hcount, o_vcount) is a visible pixel.
REQ-019 o_new_frame  output  1  single-cycle pulse at the start of vertical blanking.
REQ-020 o_frame_count  output  $clog2(FRAME_WRAP)  frame counter, 0..FRAME_WRAP-1.

Function
REQ-021 The block SHALL hold a one-bit started flag, cleared by reset and set on the first rising edge after reset release.
REQ-022 On the edge that sets the started flag, the counters SHALL remain at (0,0).
REQ-023 On each subsequent edge, o_hcount SHALL increment by 1 and SHALL wrap from H_TOTAL-1 to 0.
REQ-024 o_vcount SHALL increment only on the edge where o_hcount wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-025 All outputs SHALL be decoded from registered state, with zero-cycle skew relative to o_hcount and o_vcount.
REQ-026 All outputs SHALL be free of combinational paths from any input.
REQ-027 o_active_draw SHALL equal started AND (o_hcount < ACTIVE_H) AND (o_vcount < ACTIVE_V).
REQ-028 o_hsync SHALL be at SYNC_ACTIVE iff started AND ACTIVE_H+H_FRONT <= o_hcount < ACTIVE_H+H_FRONT+H_SYNC (656..751), and at the inverse level otherwise.
REQ-029 o_vsync SHALL be at SYNC_ACTIVE iff started AND ACTIVE_V+V_FRONT <= o_vcount < ACTIVE_V+V_FRONT+V_SYNC (490..491), independent of o_hcount, and at the inverse level otherwise.
REQ-030 o_new_frame SHALL be high for exactly the one cycle where o_hcount == ACTIVE_H and o_vcount == ACTIVE_V (640,480), once per frame.
REQ-031 o_frame_count SHALL increment on the edge that ends the o_new_frame cycle, and SHALL wrap from FRAME_WRAP-1 to 0.
REQ-032 Frame period SHALL be exactly H_TOTAL*V_TOTAL cycles (420000 at defaults), and line period SHALL be exactly H_TOTAL cycles.
REQ-033 Counter arithmetic SHALL be unsigned, and no out-of-range count value SHALL ever appear on o_hcount or o_vcount.
REQ-034 Simultaneous wraps of o_hcount and o_vcount at (H_TOTAL-1, V_TOTAL-1) SHALL land on (0,0) in one edge.

Reset
REQ-035 While i_rst_n is low, the block SHALL drive o_hcount=0, o_vcount=0, o_active_draw=0, o_new_frame=0 and o_frame_count=0, with the started flag clear.
REQ-036 While i_rst_n is low, o_hsync and o_vsync SHALL be at the inverse of SYNC_ACTIVE (1 at defaults).
REQ-037 Reset assertion at any point, including mid-line or mid-sync, SHALL force the REQ-035/REQ-036 values immediately, without waiting for a clock edge.
REQ-038 After reset release, the block SHALL restart per REQ-021/REQ-022 with no residual frame state.

Verification
REQ-039 Reset low, then release -> outputs at reset values; first edge gives (0,0) with o_active_draw=1; second edge gives o_hcount=1.
REQ-040 Run one line from (0,0) -> o_active_draw high for cycles 0..639; o_hsync=0 for exactly 96 cycles at hcount 656..751; o_vcount becomes 1 at cycle 800.
REQ-041 Run two full frames -> exactly one o_new_frame pulse per 420000 cycles at (640,480); o_vsync=0 for exactly 1600 cycles per frame; o_frame_count goes 0->1->2.
REQ-042 Run 60 frames -> o_frame_count reaches 59, then wraps to 0 on the 60th o_new_frame.
REQ-043 At (799,524) -> next edge gives (0,0); o_active_draw rises; no o_new_frame pulse on that edge.
REQ-044 Assert i_rst_n low asynchronously mid-hsync at (700,491) -> o_hsync=1, o_vsync=1 and counts=0 before the next edge; after release, restart per REQ-039.
